// File: rtl/decode_issue_stage_pkg.sv
// Shared types for the decode/issue stage: instruction field map, decoded bundle, opcode helpers.
package decode_issue_stage_pkg;

  localparam int INSTR_W = 9;
  localparam int RADDR_W = 3;
  localparam int IMM_W   = 3;
  localparam int TAG_W   = 8;

  localparam int OP_MSB = 8;
  localparam int OP_LSB = 6;
  localparam int RD_MSB = 5;
  localparam int RD_LSB = 3;
  localparam int RS_MSB = 2;
  localparam int RS_LSB = 0;

  typedef enum logic [2:0] {
    OP_AND = 3'b010,
    OP_XOR = 3'b011,
    OP_ROL = 3'b100,
    OP_MOV = 3'b111
  } op_mne;

  typedef struct packed {
    op_mne              op;
    logic [RADDR_W-1:0] rd;
    logic [RADDR_W-1:0] rs;
    logic [IMM_W-1:0]   imm;
    logic               we;
    logic [TAG_W-1:0]   pc_tag;
  } dec_bundle_t;

  typedef enum logic [1:0] {
    BUF_EMPTY = 2'd0,
    BUF_ONE   = 2'd1,
    BUF_FULL  = 2'd2
  } buf_state_e;

  function automatic logic is_legal_op(input logic [2:0] op);
    case (op)
      3'b010, 3'b011, 3'b100, 3'b111: return 1'b1;
      default:                        return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/decode_issue_stage_skid_buffer_2.sv
// Generic 2-entry valid/ready skid buffer; in_ready and out_valid come straight from flops.
module skid_buffer_2
  import decode_issue_stage_pkg::*;
#(
  parameter type T = logic [7:0]
) (
  input  logic clk,
  input  logic rst_n,
  input  logic flush,
  input  logic in_valid,
  input  T     in_data,
  output logic in_ready,
  output logic out_valid,
  output T     out_data,
  input  logic out_ready
);

  buf_state_e state_q, state_d;
  T           main_q, skid_q;
  logic       in_ready_q, out_valid_q;
  logic       accept, ld_main, ld_skid, mv_skid;

  assign accept = in_valid && in_ready_q && !flush;

  always_comb begin
    state_d = state_q;
    ld_main = 1'b0;
    ld_skid = 1'b0;
    mv_skid = 1'b0;
    if (flush) begin
      // Any output transfer this cycle still completes; everything left is dropped.
      state_d = BUF_EMPTY;
    end else begin
      case (state_q)
        BUF_EMPTY: if (accept) begin
          state_d = BUF_ONE;
          ld_main = 1'b1;
        end
        BUF_ONE: begin
          if (accept && out_ready) begin
            ld_main = 1'b1;
          end else if (accept) begin
            state_d = BUF_FULL;
            ld_skid = 1'b1;
          end else if (out_ready) begin
            state_d = BUF_EMPTY;
          end
        end
        BUF_FULL: if (out_ready) begin
          state_d = BUF_ONE;
          mv_skid = 1'b1;
        end
        default: state_d = BUF_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= BUF_EMPTY;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= (state_d != BUF_FULL);
      out_valid_q <= (state_d != BUF_EMPTY);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_q <= '0;
      skid_q <= '0;
    end else begin
      if (ld_main)      main_q <= in_data;
      else if (mv_skid) main_q <= skid_q;
      if (ld_skid)      skid_q <= in_data;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = main_q;

endmodule

// File: rtl/decode_issue_stage.sv
// Decode/issue stage feeding the ALU through a 2-entry skid buffer.
// Optional illegal-opcode trap: define DECODE_ILLEGAL_TRAP_EN.
module decode_issue_stage
  import decode_issue_stage_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  input  logic               in_valid,
  input  logic [INSTR_W-1:0] in_instr,
  output logic               in_ready,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2:0]         out_op,
  output logic [RADDR_W-1:0] out_rd,
  output logic [RADDR_W-1:0] out_rs,
  output logic [IMM_W-1:0]   out_imm,
  output logic               out_we,
  output logic [TAG_W-1:0]   out_pc_tag
`ifdef DECODE_ILLEGAL_TRAP_EN
  ,
  output logic               illegal_pulse,
  output logic               illegal_sticky,
  output logic [7:0]         illegal_count
`endif
);

  logic [2:0]       op_raw;
  logic [TAG_W-1:0] seq_q;
  logic             accept, buf_valid;
  dec_bundle_t      dec, out_b;

  assign op_raw = in_instr[OP_MSB:OP_LSB];
  assign accept = in_valid && in_ready && !flush;

  always_comb begin
    dec.op     = OP_MOV;
    dec.rd     = in_instr[RD_MSB:RD_LSB];
    dec.rs     = in_instr[RS_MSB:RS_LSB];
    dec.imm    = '0;
    dec.we     = 1'b1;
    dec.pc_tag = seq_q;
    case (op_raw)
      3'b010: dec.op = OP_AND;
      3'b011: dec.op = OP_XOR;
      3'b100: begin
        dec.op  = OP_ROL;
        dec.rs  = '0;
        dec.imm = in_instr[RS_MSB:RS_LSB];
      end
      3'b111: dec.op = OP_MOV;
      default: dec.we = 1'b0;  // undefined opcode issues as a NOP move
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      seq_q <= '0;
    else if (accept) seq_q <= seq_q + 1'b1;
  end

`ifdef DECODE_ILLEGAL_TRAP_EN
  logic       legal;
  logic       pulse_q, sticky_q;
  logic [7:0] count_q;

  assign legal     = is_legal_op(op_raw);
  // Illegal words still consume a handshake and a tag, but never reach the buffer.
  assign buf_valid = in_valid && legal;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pulse_q  <= 1'b0;
      sticky_q <= 1'b0;
      count_q  <= '0;
    end else begin
      pulse_q <= accept && !legal;
      if (flush)        sticky_q <= 1'b0;
      else if (pulse_q) sticky_q <= 1'b1;
      if (pulse_q && count_q != 8'hff) count_q <= count_q + 1'b1;
    end
  end

  assign illegal_pulse  = pulse_q;
  assign illegal_sticky = sticky_q;
  assign illegal_count  = count_q;
`else
  assign buf_valid = in_valid;
`endif

  skid_buffer_2 #(.T(dec_bundle_t)) u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (buf_valid),
    .in_data   (dec),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_b),
    .out_ready (out_ready)
  );

  assign out_op     = out_b.op;
  assign out_rd     = out_b.rd;
  assign out_rs     = out_b.rs;
  assign out_imm    = out_b.imm;
  assign out_we     = out_b.we;
  assign out_pc_tag = out_b.pc_tag;

endmodule

// File: tb/tb_decode_issue_stage.sv
// Scoreboarded directed test of decode_issue_stage (default build, trap feature off).
module tb_decode_issue_stage;

  logic       clk, rst_n, flush, in_valid, in_ready, out_valid, out_ready, out_we;
  logic [8:0] in_instr;
  logic [2:0] out_op, out_rd, out_rs, out_imm;
  logic [7:0] out_pc_tag;

  typedef struct packed {
    logic [2:0] op;
    logic [2:0] rd;
    logic [2:0] rs;
    logic [2:0] imm;
    logic       we;
    logic [7:0] tag;
  } exp_t;

  exp_t       sb[$];
  int         total = 0;
  int         bad = 0;
  int         cyc = 0;
  logic [7:0] exp_tag = 8'd0;

  decode_issue_stage dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_instr(in_instr),
    .in_ready(in_ready), .out_valid(out_valid), .out_ready(out_ready), .out_op(out_op),
    .out_rd(out_rd), .out_rs(out_rs), .out_imm(out_imm), .out_we(out_we), .out_pc_tag(out_pc_tag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Monitor: every output transfer must match the oldest expected bundle.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      exp_t got, e;
      got = '{out_op, out_rd, out_rs, out_imm, out_we, out_pc_tag};
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL sb_unexpected: got %h want none", got);
      end else begin
        e = sb.pop_front();
        if (got !== e) begin
          bad++;
          $display("FAIL sb_bundle: got op=%b rd=%0d rs=%0d imm=%0d we=%b tag=%0d want op=%b rd=%0d rs=%0d imm=%0d we=%b tag=%0d",
                   got.op, got.rd, got.rs, got.imm, got.we, got.tag, e.op, e.rd, e.rs, e.imm, e.we, e.tag);
        end
      end
    end
  end

  task automatic send(input logic [8:0] ins, input logic [2:0] op, input logic [2:0] rd,
                      input logic [2:0] rs, input logic [2:0] imm, input logic we);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_instr = ins;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      total++;
      bad++;
      $display("FAIL send_timeout: got in_ready=0 want 1");
    end else begin
      sb.push_back('{op, rd, rs, imm, we, exp_tag});
      exp_tag++;
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    int c0;
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_instr = '0; out_ready = 1'b0;

    // Reset
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid_in_reset", {31'd0, out_valid}, 32'd0);
    rst_n = 1'b1;
    idle(1);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_pc_tag", {24'd0, out_pc_tag}, 32'd0);
    chk("rst_out_op", {29'd0, out_op}, 32'd0);

    // Back-to-back throughput with tags 0..3
    out_ready = 1'b1;
    c0 = cyc;
    send(9'b010_001_010, 3'b010, 3'd1, 3'd2, 3'd0, 1'b1);
    chk("latency_valid", {31'd0, out_valid}, 32'd1);
    chk("latency_tag", {24'd0, out_pc_tag}, 32'd0);
    send(9'b011_110_101, 3'b011, 3'd6, 3'd5, 3'd0, 1'b1);
    send(9'b100_111_011, 3'b100, 3'd7, 3'd0, 3'd3, 1'b1);
    send(9'b111_000_100, 3'b111, 3'd0, 3'd4, 3'd0, 1'b1);
    chk("throughput_cycles", cyc - c0, 32'd4);
    idle(2);

    // Stall into FULL, hold, then drain in order
    out_ready = 1'b0;
    send(9'b100_011_101, 3'b100, 3'd3, 3'd0, 3'd5, 1'b1);
    send(9'b111_010_110, 3'b111, 3'd2, 3'd6, 3'd0, 1'b1);
    chk("full_in_ready", {31'd0, in_ready}, 32'd0);
    for (int k = 0; k < 3; k++) begin
      idle(1);
      chk("hold_op", {29'd0, out_op}, 32'b100);
      chk("hold_imm", {29'd0, out_imm}, 32'd5);
      chk("hold_tag", {24'd0, out_pc_tag}, 32'd4);
    end
    out_ready = 1'b1;
    idle(1);
    chk("drain_in_ready", {31'd0, in_ready}, 32'd1);
    chk("drain_next_tag", {24'd0, out_pc_tag}, 32'd5);
    idle(2);

    // Flush with two buffered bundles and a simultaneous request
    out_ready = 1'b0;
    send(9'b010_000_001, 3'b010, 3'd0, 3'd1, 3'd0, 1'b1);
    send(9'b011_001_000, 3'b011, 3'd1, 3'd0, 3'd0, 1'b1);
    in_valid = 1'b1; in_instr = 9'b111_111_111; flush = 1'b1;
    sb.delete();
    idle(1);
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_out_valid", {31'd0, out_valid}, 32'd0);
    chk("flush_in_ready", {31'd0, in_ready}, 32'd1);
    // Flush beats an accept that would otherwise succeed
    in_valid = 1'b1; in_instr = 9'b010_010_010; flush = 1'b1;
    idle(1);
    flush = 1'b0; in_valid = 1'b0;
    idle(1);
    chk("flush_drop_valid", {31'd0, out_valid}, 32'd0);
    out_ready = 1'b1;
    send(9'b111_101_011, 3'b111, 3'd5, 3'd3, 3'd0, 1'b1);
    chk("post_flush_tag", {24'd0, out_pc_tag}, 32'd8);
    idle(2);

    // Undefined opcode becomes a NOP move
    send(9'b101_100_001, 3'b111, 3'd4, 3'd1, 3'd0, 1'b0);
    chk("nop_we", {31'd0, out_we}, 32'd0);
    idle(2);

    // 257 instructions: tag wraps 255 -> 0 -> 1
    for (int i = 0; i < 257; i++) begin
      logic [8:0] w;
      w = {3'b111, i[5:0]};
      send(w, 3'b111, w[5:3], w[2:0], 3'd0, 1'b1);
    end
    idle(2);
    chk("wrap_tag_model", {24'd0, exp_tag}, 32'd11);

    // Async reset in the middle of a stall
    out_ready = 1'b0;
    send(9'b111_001_001, 3'b111, 3'd1, 3'd1, 3'd0, 1'b1);
    send(9'b111_010_010, 3'b111, 3'd2, 3'd2, 3'd0, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid", {31'd0, out_valid}, 32'd0);
    chk("async_rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("async_rst_tag", {24'd0, out_pc_tag}, 32'd0);
    sb.delete();
    exp_tag = 8'd0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    idle(1);
    send(9'b010_111_110, 3'b010, 3'd7, 3'd6, 3'd0, 1'b1);
    chk("post_rst_tag", {24'd0, out_pc_tag}, 32'd0);
    idle(3);
    chk("sb_empty", sb.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
